// File: rtl/overlay_fetch_ctrl.sv
// Overlay stream fetch: buffers 64-bit HPS words, unpacks four ARGB1555 pixels per word,
// substitutes transparent pixels on underrun. Optional chroma key via OVL_CHROMA_KEY_EN.
module overlay_fetch_ctrl #(
    parameter int unsigned FIFO_AW    = 3,
    parameter logic [15:0] CHROMA_KEY = 16'h7C1F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] info_resolution,
    input  logic [63:0] ovl_data,
    input  logic        ovl_valid,
    output logic        ovl_ready,
    input  logic        frame_start,
    input  logic        pix_req,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned OW    = FIFO_AW + 1;
    localparam logic [OW-1:0] OWED_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [63:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [63:0]          held_q, held_d;
    logic                 held_vld_q, held_vld_d;
    logic [1:0]           lane_q, lane_d;
    logic [OW-1:0]        owed_q, owed_d;
    logic [31:0]          total_q, total_d, pix_cnt_q, pix_cnt_d;
    logic [15:0]          pix_data_q, pix_data_d;
    logic                 pix_valid_q, pix_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 underrun_q, underrun_d;
    logic [15:0]          underrun_cnt_q, underrun_cnt_d;
    logic                 ovl_ready_q, ovl_ready_d;

    logic                 wr_en, rd_en, fs_ok, have_word, owed_inc;
    logic [63:0]          word;
    logic [15:0]          pix;

`ifndef OVL_CHROMA_KEY_EN
    logic [15:0] unused_chroma_key;
    assign unused_chroma_key = CHROMA_KEY;
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        held_d         = held_q;
        held_vld_d     = held_vld_q;
        lane_d         = lane_q;
        owed_d         = owed_q;
        total_d        = total_q;
        pix_cnt_d      = pix_cnt_q;
        pix_data_d     = pix_data_q;
        pix_valid_d    = 1'b0;
        frame_done_d   = 1'b0;
        underrun_d     = underrun_q;
        underrun_cnt_d = underrun_cnt_q;
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        have_word      = 1'b0;
        owed_inc       = 1'b0;
        word           = '0;
        pix            = '0;
        fs_ok          = frame_start && (info_resolution[15:0] != 16'd0)
                                     && (info_resolution[31:16] != 16'd0);

        if (!enable) begin
            state_d        = ST_IDLE;
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            cnt_d          = '0;
            held_vld_d     = 1'b0;
            lane_d         = 2'd0;
            owed_d         = '0;
            underrun_d     = 1'b0;
            underrun_cnt_d = 16'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (fs_ok) begin
                        total_d   = 32'(info_resolution[15:0]) * 32'(info_resolution[31:16]);
                        pix_cnt_d = 32'd0;
                        state_d   = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (pix_req) begin
                        if ((lane_q == 2'd0) && !held_vld_q && (cnt_q != '0)) begin
                            rd_en      = 1'b1;
                            word       = mem_q[rd_ptr_q];
                            have_word  = 1'b1;
                            held_d     = word;
                            held_vld_d = 1'b1;
                        end else if (held_vld_q) begin
                            word      = held_q;
                            have_word = 1'b1;
                        end
                        pix = word[{lane_q, 4'b0000} +: 16];
                        if (have_word) begin
`ifdef OVL_CHROMA_KEY_EN
                            if (pix[14:0] == CHROMA_KEY[14:0]) pix[15] = 1'b0;
`endif
                            pix_data_d = pix;
                        end else begin
                            pix_data_d = 16'h0000;
                            underrun_d = 1'b1;
                            if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
                        end
                        pix_valid_d = 1'b1;
                        lane_d      = lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            held_vld_d = 1'b0;
                            owed_inc   = !have_word;
                        end
                    end
                    // A fresh frame_start restarts the frame without a done pulse
                    if (fs_ok) begin
                        total_d   = 32'(info_resolution[15:0]) * 32'(info_resolution[31:16]);
                        pix_cnt_d = 32'd0;
                    end else if (pix_req) begin
                        if (pix_cnt_q == total_q - 32'd1) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_WAIT;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 32'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Words owed for missed slots are dropped before anything reaches the FIFO
            if (owed_inc && (owed_q != OWED_MAX)) owed_d = owed_q + OW'(1);
            if (ovl_valid && ovl_ready_q) begin
                if (owed_d != '0) owed_d = owed_d - OW'(1);
                else              wr_en  = 1'b1;
            end
            if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
        end

        ovl_ready_d = (state_d != ST_IDLE) && ((cnt_d != CW'(DEPTH)) || (owed_d != '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            held_q         <= '0;
            held_vld_q     <= 1'b0;
            lane_q         <= 2'd0;
            owed_q         <= '0;
            total_q        <= 32'd0;
            pix_cnt_q      <= 32'd0;
            pix_data_q     <= 16'd0;
            pix_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= 16'd0;
            ovl_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            held_q         <= held_d;
            held_vld_q     <= held_vld_d;
            lane_q         <= lane_d;
            owed_q         <= owed_d;
            total_q        <= total_d;
            pix_cnt_q      <= pix_cnt_d;
            pix_data_q     <= pix_data_d;
            pix_valid_q    <= pix_valid_d;
            frame_done_q   <= frame_done_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
            ovl_ready_q    <= ovl_ready_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by cnt_q
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= ovl_data;
    end

    assign ovl_ready    = ovl_ready_q;
    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_overlay_fetch_ctrl.sv
// Directed bench for overlay_fetch_ctrl: per-cycle vector table plus backpressure and chroma sequences.
module tb_overlay_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] info_resolution;
    logic [63:0] ovl_data;
    logic        ovl_valid;
    logic        ovl_ready;
    logic        frame_start;
    logic        pix_req;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        frame_done;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    overlay_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .info_resolution(info_resolution),
        .ovl_data       (ovl_data),
        .ovl_valid      (ovl_valid),
        .ovl_ready      (ovl_ready),
        .frame_start    (frame_start),
        .pix_req        (pix_req),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .frame_done     (frame_done),
        .underrun       (underrun),
        .underrun_cnt   (underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, fs, req, vld;
        logic [31:0] res;
        logic [63:0] data;
        logic        e_rdy, e_pv;
        logic [15:0] e_pd;
        logic        e_fd, e_ur;
        logic [15:0] e_uc;
    } vec_t;

    localparam logic [31:0] R42 = 32'h0002_0004;
    localparam logic [31:0] R81 = 32'h0001_0008;
    localparam logic [63:0] W1  = 64'h0004_0003_0002_0001;
    localparam logic [63:0] W2  = 64'h0008_0007_0006_0005;
    localparam logic [63:0] W4  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] W5  = 64'h000C_000B_000A_0009;

    function automatic vec_t mk(logic en, logic fs, logic req, logic vld, logic [31:0] res,
                                logic [63:0] data, logic e_rdy, logic e_pv, logic [15:0] e_pd,
                                logic e_fd, logic e_ur, logic [15:0] e_uc);
        vec_t v;
        v.en = en; v.fs = fs; v.req = req; v.vld = vld; v.res = res; v.data = data;
        v.e_rdy = e_rdy; v.e_pv = e_pv; v.e_pd = e_pd; v.e_fd = e_fd; v.e_ur = e_ur; v.e_uc = e_uc;
        return v;
    endfunction

    function automatic logic [63:0] mk_word(logic [15:0] base);
        return {base + 16'd3, base + 16'd2, base + 16'd1, base};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [$];

    initial begin
        int acc;
        reset_n = 1'b0; enable = 1'b0; info_resolution = '0; ovl_data = '0;
        ovl_valid = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 64'(ovl_ready), 0);
        chk("rst_pix_valid", 64'(pix_valid), 0);
        chk("rst_pix_data", 64'(pix_data), 0);
        chk("rst_frame_done", 64'(frame_done), 0);
        chk("rst_underrun", 64'(underrun), 0);
        chk("rst_underrun_cnt", 64'(underrun_cnt), 0);
        reset_n = 1'b1;
        tick();

        //             en fs rq vd res  data rdy pv pd      fd ur uc
        vecs.push_back(mk(1, 0, 0, 0, R42, 0,  1, 0, 16'h0, 0, 0, 0));   // 0 IDLE->WAIT
        vecs.push_back(mk(1, 1, 0, 0, R42, 0,  1, 0, 16'h0, 0, 0, 0));   // 1 frame 4x2
        vecs.push_back(mk(1, 0, 0, 1, R42, W1, 1, 0, 16'h0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, R42, W2, 1, 0, 16'h0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 1, 0, R42, 0, 1, 1, 16'(i + 1), (i == 7), 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, R42, 0,  1, 0, 16'h0, 0, 0, 0));   // 12
        vecs.push_back(mk(1, 1, 0, 0, 0,   0,  1, 0, 16'h0, 0, 0, 0));   // 13 zero res ignored
        vecs.push_back(mk(1, 0, 1, 0, 0,   0,  1, 0, 16'h0, 0, 0, 0));   // 14 req in WAIT
        vecs.push_back(mk(1, 1, 0, 1, R81, W1, 1, 0, 16'h0, 0, 0, 0));   // 15 frame 8x1
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 1, 0, R81, 0, 1, 1, 16'(i + 1), 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 1, 0, R81, 0, 1, 1, 16'h0, (i == 3), 1, 16'(i + 1)));
        vecs.push_back(mk(1, 0, 0, 1, R81, W4, 1, 0, 16'h0, 0, 1, 4));   // 24 owed word dropped
        vecs.push_back(mk(1, 0, 0, 1, R81, W5, 1, 0, 16'h0, 0, 1, 4));
        vecs.push_back(mk(1, 1, 0, 0, R81, 0,  1, 0, 16'h0, 0, 1, 4));
        vecs.push_back(mk(1, 0, 1, 0, R81, 0,  1, 1, 16'h9, 0, 1, 4));   // 27
        vecs.push_back(mk(1, 0, 1, 0, R81, 0,  1, 1, 16'hA, 0, 1, 4));
        vecs.push_back(mk(1, 0, 1, 0, R81, 0,  1, 1, 16'hB, 0, 1, 4));
        vecs.push_back(mk(0, 0, 1, 0, R81, 0,  0, 0, 16'h0, 0, 0, 0));   // 30 enable drop
        vecs.push_back(mk(1, 0, 0, 0, R42, 0,  1, 0, 16'h0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, R42, W1, 1, 0, 16'h0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, R42, W2, 1, 1, 16'h1, 0, 0, 0));   // 33 clean restart
        vecs.push_back(mk(1, 0, 1, 0, R42, 0,  1, 1, 16'h2, 0, 0, 0));

        foreach (vecs[i]) begin
            enable = vecs[i].en; frame_start = vecs[i].fs; pix_req = vecs[i].req;
            ovl_valid = vecs[i].vld; info_resolution = vecs[i].res; ovl_data = vecs[i].data;
            tick();
            chk($sformatf("v%0d_ready", i), 64'(ovl_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("v%0d_pix_valid", i), 64'(pix_valid), 64'(vecs[i].e_pv));
            if (vecs[i].e_pv)
                chk($sformatf("v%0d_pix_data", i), 64'(pix_data), 64'(vecs[i].e_pd));
            chk($sformatf("v%0d_frame_done", i), 64'(frame_done), 64'(vecs[i].e_fd));
            chk($sformatf("v%0d_underrun", i), 64'(underrun), 64'(vecs[i].e_ur));
            chk($sformatf("v%0d_underrun_cnt", i), 64'(underrun_cnt), 64'(vecs[i].e_uc));
        end
        frame_start = 1'b0; pix_req = 1'b0; ovl_valid = 1'b0;

        // Backpressure: FIFO of 8 words fills, one pop reopens it
        enable = 1'b0; tick();
        enable = 1'b1; tick();
        info_resolution = R42; frame_start = 1'b1; tick();
        frame_start = 1'b0;
        acc = 0;
        ovl_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ovl_data = mk_word(16'h0100 + 16'(acc * 4));
            if (ovl_ready) acc++;
            tick();
        end
        chk("bp_accepts", 64'(acc), 8);
        chk("bp_ready_low", 64'(ovl_ready), 0);
        ovl_valid = 1'b0; pix_req = 1'b1; tick();
        pix_req = 1'b0;
        chk("bp_pop_valid", 64'(pix_valid), 1);
        chk("bp_pop_data", 64'(pix_data), 64'h0100);
        chk("bp_ready_again", 64'(ovl_ready), 1);
        ovl_valid = 1'b1; ovl_data = mk_word(16'h0200); tick();
        ovl_valid = 1'b0;
        chk("bp_refull", 64'(ovl_ready), 0);

        // Chroma key handling on a keyed and a near-key pixel
        enable = 1'b0; tick();
        enable = 1'b1; tick();
        frame_start = 1'b1; ovl_valid = 1'b1;
        ovl_data = {16'h0000, 16'h0000, 16'hFC1E, 16'hFC1F}; tick();
        frame_start = 1'b0; ovl_valid = 1'b0; pix_req = 1'b1; tick();
`ifdef OVL_CHROMA_KEY_EN
        chk("ck_keyed", 64'(pix_data), 64'h7C1F);
`else
        chk("ck_keyed", 64'(pix_data), 64'hFC1F);
`endif
        tick();
        pix_req = 1'b0;
        chk("ck_unkeyed", 64'(pix_data), 64'hFC1E);
        chk("ck_valid", 64'(pix_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/overlay_fetch_ctrl.md
Name: overlay_fetch_ctrl

Overview:
Sequences the 64-bit overlay stream from the HPS into the video overlay pixel path. Buffers stream words in a small FIFO and unpacks each word into four 16-bit ARGB1555 pixels. Delivers one pixel per pix_req inside a frame sized by info_resolution. On underrun it substitutes transparent pixels and keeps stream alignment by discarding the words it owes.

Parameters:
FIFO_AW, 3, log2 of FIFO depth in 64-bit words (depth 8)
CHROMA_KEY, 16'h7C1F, RGB key compared against bits [14:0]; used only with OVL_CHROMA_KEY_EN

Ports:
clk  in  1  system clock, all logic rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low = idle and flush
info_resolution  in  32  [15:0] width in pixels, [31:16] height in lines
ovl_data  in  64  overlay stream word; pixel k = bits [16k+15:16k], k=0 first
ovl_valid  in  1  stream word valid
ovl_ready  out  1  stream word accepted when valid&&ready
frame_start  in  1  one-cycle pulse at start of video frame
pix_req  in  1  pixel pipeline requests next pixel this cycle
pix_data  out  16  ARGB1555 pixel; bit15 = opaque
pix_valid  out  1  pix_data valid, exactly 1 cycle after pix_req
frame_done  out  1  one-cycle pulse when last pixel of frame issued
underrun  out  1  sticky; set on any substituted pixel, cleared by enable low
underrun_cnt  out  16  substituted-pixel count, saturates at 16'hFFFF, cleared by enable low

Behaviour:
- Reset: state IDLE, FIFO empty, lane=0, held word invalid, owed=0, pixel counter 0; every output 0.
- States:
  - IDLE: ovl_ready=0. If enable=1, go to WAIT next cycle.
  - WAIT: wait for frame_start. On frame_start with width!=0 and height!=0, latch width, height and total=width*height (32-bit), clear the pixel counter, go to ACTIVE. A frame_start with zero width or height is ignored.
  - ACTIVE: serve pix_req. When pixel counter reaches total-1 and that pixel issues, pulse frame_done the same cycle as its pix_valid, then go to WAIT.
- enable low in any state: IDLE next cycle. This flushes the FIFO and clears the held word, lane, owed, underrun and underrun_cnt. pix_valid and frame_done are forced 0 from that cycle.
- ovl_ready = (state!=IDLE) && (!fifo_full || owed!=0).
- Accepted word handling:
  - owed!=0: word is discarded and owed decrements.
  - owed=0: word is written to the FIFO.
  - A write to a full FIFO is impossible by construction.
- Simultaneous FIFO read and write when full is allowed and keeps the FIFO full.
- Pixel issue in ACTIVE, per pix_req (latency 1):
  - If lane=0 and the held word is invalid, pop the FIFO into the held word.
  - Output pixel[lane]; lane = lane+1 mod 4; at lane wrap, mark the held word invalid.
- Underrun: pixel needed and FIFO empty with no held word.
  - Output 16'h0000 with pix_valid=1, set underrun, increment underrun_cnt.
  - Lane still advances. On the wrap of a fully or partly missed word, owed increments (saturating at 2^FIFO_AW+1 bits max), so later words realign.
- pix_req outside ACTIVE: ignored, no pix_valid.
- Early frame_start in ACTIVE: treated as a new frame. Counters restart and resolution is relatched. FIFO, held word and lane are kept. No frame_done pulse.
- Width must be a multiple of 4. Other widths are unsupported; the lane simply continues across lines.

Optional Feature:
OVL_CHROMA_KEY_EN:
- Defined: a non-substituted pixel whose bits [14:0] equal CHROMA_KEY[14:0] is output with bit15 forced to 0. Adds no latency.
- Undefined: pixels pass through unmodified and CHROMA_KEY is unused.

Test Plan:
- Basic frame: res=4x2, enable, frame_start, push 2 words 0x0004_0003_0002_0001 and 0x0008_..._0005, 8 pix_req → pix_data 1..8 in order; frame_done with the 8th pix_valid; underrun=0.
- Backpressure: FIFO_AW=3, push 12 words, no pix_req → ovl_ready drops after exactly 8 accepts; one pix_req → ready high again.
- Underrun: res=8x1, one word queued, 8 pix_req → pixels 1..4, then 4×0x0000; underrun=1, underrun_cnt=4. Next arriving word is discarded (owed 1→0), and the following word is delivered in the next frame.
- Zero resolution: info_resolution=0, frame_start → stays WAIT, pix_req gives no pix_valid.
- Enable drop mid-frame: deassert enable after 3 pixels → next cycle ovl_ready=0, pix_valid=0, underrun_cnt=0; re-enable and a new frame starts clean at pixel 1.
- Chroma key (macro on): word containing 0xFC1F → output 0x7C1F; 0xFC1E → unchanged.
